// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding imem request, a 2-entry {pc, instr}
// FIFO toward IF/ID, and redirect-driven flush with drain of the in-flight reply.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [31:0] in0_q, in0_d, in1_q, in1_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        req, gnt, push, pop;
  logic [31:0] push_pc;

  // Request is combinational so it drops in the same cycle as redirect or reset.
  assign req         = (state_q == IDLE) && !redirect_i && (cnt_q != 2'd2) && !rst_i;
  assign gnt         = req && imem_gnt_i;
  assign imem_req_o  = req;
  assign imem_addr_o = fetch_pc_q;

  assign valid_o = (cnt_q != 2'd0);
  assign pc_o    = valid_o ? pc0_q : '0;
  assign instr_o = valid_o ? in0_q : '0;
  assign pop     = valid_o && !stall_i && !redirect_i;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    pc0_d      = pc0_q;
    pc1_d      = pc1_q;
    in0_d      = in0_q;
    in1_d      = in1_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    push_pc    = req_pc_q;

    case (state_q)
      IDLE: begin
        if (gnt) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          if (imem_rvalid_i) begin
            push    = 1'b1;
            push_pc = fetch_pc_q;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (imem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Entry 0 is always the head; the FIFO shifts on pop.
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          pc0_d = push_pc;
          in0_d = imem_rdata_i;
        end else begin
          pc1_d = push_pc;
          in1_d = imem_rdata_i;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        pc0_d = pc1_q;
        in0_d = in1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          pc0_d = push_pc;
          in0_d = imem_rdata_i;
        end else begin
          pc0_d = pc1_q;
          in0_d = in1_q;
          pc1_d = push_pc;
          in1_d = imem_rdata_i;
        end
      end
      default: ;
    endcase

    // Redirect wins; a DRAIN whose reply lands this cycle still returns to IDLE,
    // otherwise nothing would ever leave DRAIN.
    if (redirect_i) begin
      cnt_d      = 2'd0;
      fetch_pc_d = redirect_pc_i & 32'hFFFF_FFFC;
      if (state_q == WAIT) state_d = imem_rvalid_i ? IDLE : DRAIN;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      pc0_q      <= '0;
      pc1_q      <= '0;
      in0_q      <= '0;
      in1_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      pc0_q      <= pc0_d;
      pc1_q      <= pc1_d;
      in0_q      <= in0_d;
      in1_q      <= in1_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: behavioural imem with selectable latency, scoreboard of
// granted fetches, and directed redirect / stall / wrap / reset scenarios.
module tb_if_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i, valid_o;
  logic [31:0] imem_addr_o, imem_rdata_i, pc_o, instr_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [63:0] sb[$];
  int unsigned lat = 0;
  bit          pend = 1'b0;
  int unsigned pcnt = 0;
  logic [31:0] paddr = '0;

  if_fetch #(.RESET_PC(RST_PC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i),
    .pc_o(pc_o), .instr_o(instr_o), .valid_o(valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // what: 1 = granted request, otherwise any request
  task automatic wait_for(input int unsigned what, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk_i);
      #1;
      ok = (what == 1) ? (imem_req_o && imem_gnt_i) : imem_req_o;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  // Output monitor and memory model share one block so flush precedes new pushes.
  always @(negedge clk_i) begin
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (rst_i) begin
      sb.delete();
      pend = 1'b0;
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_req", 32'(imem_req_o), 32'd0);
    end else begin
      if (valid_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'(valid_o), 32'd0);
        end else begin
          chk("pc_o", pc_o, sb[0][63:32]);
          chk("instr_o", instr_o, sb[0][31:0]);
          if (!stall_i && !redirect_i) void'(sb.pop_front());
        end
      end else begin
        chk("empty_pc", pc_o, 32'd0);
        chk("empty_instr", instr_o, 32'd0);
      end
      if (redirect_i) sb.delete();

      if (pend) begin
        if (pcnt == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = paddr ^ KEY;
          pend          = 1'b0;
        end else begin
          pcnt--;
        end
      end else if (imem_req_o) begin
        imem_gnt_i = 1'b1;
        sb.push_back({imem_addr_o, imem_addr_o ^ KEY});
        if (lat == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = imem_addr_o ^ KEY;
        end else begin
          pend  = 1'b1;
          paddr = imem_addr_o;
          pcnt  = lat - 1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;

    // Reset outputs, then first request right after release
    #1 rst_i = 1'b1;
    #1;
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_pc", pc_o, 32'd0);
    chk("reset_instr", instr_o, 32'd0);
    chk("reset_req", 32'(imem_req_o), 32'd0);
    step(2);
    rst_i = 1'b0;
    #1;
    chk("first_req", 32'(imem_req_o), 32'd1);
    chk("first_addr", imem_addr_o, RST_PC);

    // Zero-wait stream: one instruction per cycle
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("stream_valid", 32'(valid_o), 32'd1);
      chk("stream_pc", pc_o, RST_PC + 32'(i) * 32'd4);
    end

    // Redirect to 0 under stall, then 3-cycle memory fills the FIFO
    lat = 3; stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0000;
    step(1);
    redirect_i = 1'b0;
    #1;
    chk("post_redirect_valid", 32'(valid_o), 32'd0);
    step(14);
    chk("full_req_low", 32'(imem_req_o), 32'd0);
    chk("full_head_pc", pc_o, 32'd0);
    step(2);
    chk("full_req_still_low", 32'(imem_req_o), 32'd0);
    stall_i = 1'b0;
    step(1);
    chk("drain_second_pc", pc_o, 32'd4);
    step(3);

    // Redirect while a request is outstanding
    wait_for(1, "wait_grant_timeout");
    @(posedge clk_i); #1;
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
    step(1);
    redirect_i = 1'b0;
    #1;
    chk("drain_valid", 32'(valid_o), 32'd0);
    chk("drain_req", 32'(imem_req_o), 32'd0);
    wait_for(2, "wait_req_timeout");
    chk("redirect_addr", imem_addr_o, 32'h0000_0100);
    step(10);

    // Redirect + stall with a full FIFO
    stall_i = 1'b1;
    step(14);
    chk("full2_req_low", 32'(imem_req_o), 32'd0);
    chk("full2_valid", 32'(valid_o), 32'd1);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    step(1);
    redirect_i = 1'b0;
    #1;
    chk("flush_valid", 32'(valid_o), 32'd0);
    chk("flush_req", 32'(imem_req_o), 32'd1);
    chk("flush_addr", imem_addr_o, 32'h0000_0200);
    stall_i = 1'b0;
    step(8);

    // Address wrap at the top of the address space
    lat = 0;
    step(8);
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
    step(1);
    redirect_i = 1'b0;
    #1;
    chk("wrap_addr0", imem_addr_o, 32'hFFFF_FFF8);
    step(1);
    chk("wrap_addr1", imem_addr_o, 32'hFFFF_FFFC);
    step(1);
    chk("wrap_addr2", imem_addr_o, 32'h0000_0000);
    step(3);

    // Asynchronous reset mid-cycle while in WAIT holding one entry
    lat = 3; stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0300;
    step(1);
    redirect_i = 1'b0;
    wait_for(1, "wait_grant1_timeout");
    wait_for(1, "wait_grant2_timeout");
    @(posedge clk_i); #1;
    chk("pre_rst_valid", 32'(valid_o), 32'd1);
    #1 rst_i = 1'b1;
    #1;
    chk("async_rst_valid", 32'(valid_o), 32'd0);
    chk("async_rst_pc", pc_o, 32'd0);
    chk("async_rst_instr", instr_o, 32'd0);
    chk("async_rst_req", 32'(imem_req_o), 32'd0);
    step(2);
    rst_i = 1'b0; stall_i = 1'b0; lat = 0;
    #1;
    chk("post_rst_req", 32'(imem_req_o), 32'd1);
    chk("post_rst_addr", imem_addr_o, RST_PC);
    step(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk_i  in  1  single clock; all state updates on posedge.
REQ-003 rst_i  in  1  asynchronous, active-high reset.
REQ-004 stall_i  in  1  downstream IF/ID holding; head entry SHALL NOT be consumed.
REQ-005 redirect_i  in  1  branch taken / flush from ID.
REQ-006 redirect_pc_i  in  32  new fetch address.
REQ-007 imem_req_o  out  1  fetch request to instruction memory.
REQ-008 imem_addr_o  out  32  fetch address, word aligned.
REQ-009 imem_gnt_i  in  1  request accepted this cycle; ignored when imem_req_o=0.
REQ-010 imem_rvalid_i  in  1  read data valid for the oldest accepted request.
REQ-011 imem_rdata_i  in  32  instruction word.
REQ-012 pc_o  out  32  PC of the presented instruction.
REQ-013 instr_o  out  32  presented instruction.
REQ-014 valid_o  out  1  pc_o/instr_o hold a real instruction.

Function
REQ-015 Block SHALL hold fetch_pc, a 2-entry FIFO of {pc, instr}, a req_pc register, and an FSM with states IDLE, WAIT, DRAIN.
REQ-016 At most one accepted-but-unanswered request SHALL exist at any time.
REQ-017 imem_req_o=1 only when state=IDLE, redirect_i=0, and FIFO count<2; imem_addr_o=fetch_pc.
REQ-018 imem_req_o and imem_addr_o SHALL stay stable until imem_gnt_i, except that they drop in any cycle with redirect_i=1.
REQ-019 On grant: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), IDLE->WAIT.
REQ-020 Grant and rvalid in the same cycle: response belongs to that request, is pushed with pc=fetch_pc, and state stays IDLE.
REQ-021 WAIT with imem_rvalid_i: push {req_pc, imem_rdata_i}, WAIT->IDLE.
REQ-022 DRAIN with imem_rvalid_i: data discarded, no push, DRAIN->IDLE.
REQ-023 valid_o = FIFO not empty; pc_o/instr_o = head entry; when empty, pc_o=0 and instr_o=0.
REQ-024 Pop at posedge when valid_o=1, stall_i=0, and redirect_i=0.
REQ-025 Push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-026 A push SHALL never find the FIFO full; the request gating in REQ-017 guarantees this.
REQ-027 Redirect (priority over stall, push, pop, grant) SHALL clear the FIFO and set fetch_pc<={redirect_pc_i[31:2],2'b00}.
REQ-028 On redirect, WAIT->DRAIN if no rvalid this cycle, else ->IDLE with the data dropped; IDLE stays IDLE; DRAIN stays DRAIN.
REQ-029 Outputs presented in the cycle after a redirect SHALL be 0/0/valid_o=0.
REQ-030 No new request SHALL issue in DRAIN.

Reset
REQ-031 On rst_i=1, asynchronously: fetch_pc=RESET_PC, req_pc=0, FIFO empty, state=IDLE.
REQ-032 During reset, outputs SHALL be valid_o=0, pc_o=0, instr_o=0, imem_req_o=0.
REQ-033 Reset asserted mid-request SHALL abandon the request; any later rvalid from it is outside scope (memory is reset too).
REQ-034 First request SHALL appear in the first cycle after rst_i falls.

Verification
REQ-035 Zero-wait memory (gnt=rvalid=1 same cycle, rdata=addr^32'hA5A5_0000), stall_i=0 -> stream pc_o=0,4,8,... with matching instr_o, one per cycle after the first.
REQ-036 Memory with 3-cycle latency, stall_i held high 10 cycles -> FIFO fills to 2, imem_req_o=0 while full, entries for pc 0 and 4 emitted in order after release.
REQ-037 redirect_i=1 with redirect_pc_i=32'h0000_0103 while in WAIT -> next response dropped, next request addr=32'h0000_0100, no stale pc reaches pc_o.
REQ-038 redirect_i and stall_i both 1 with FIFO full -> FIFO emptied, valid_o=0 next cycle, fetch resumes at target.
REQ-039 fetch_pc=32'hFFFF_FFFC granted -> next imem_addr_o=0.
REQ-040 rst_i pulsed asynchronously (mid-cycle) in WAIT with FIFO holding 1 entry -> outputs 0 immediately, first post-reset request addr=RESET_PC.
